// File: rtl/smem_bck_scheduler.sv
// -----------------------------------------------------------------------------
// smem_bck_scheduler
//
// Ring-slot scheduler for the backward-extension pipeline. Each cycle it
// chooses what enters stage 2: a new read (BCK_INI), a recirculating live
// token (BCK_RUN) or a BUBBLE. New reads are admitted under an in-flight
// credit limit. A read is retired when its token comes back from the ring
// tail with finish_sign set.
//
// Ports
//   clk, rst             clock; synchronous active-low reset
//   stall                freezes every register and blocks admission
//   sched_en             admission enable (low = drain mode)
//   in_valid/in_ready    new-read handshake (in_ready is combinational)
//   in_read_num          read index of the offered read
//   in_forward_size      forward-phase size of the offered read
//   ret_status           status of the token returning from the ring tail
//   ret_finish           finish_sign of the returning token
//   ret_read_num         read index of the returning token
//   out_*                registered fields injected into stage 2
//   done_valid/read_num  registered one-cycle retire report
//   inflight             reads currently in the ring
//   retired_cnt          total retirements (wraps at 2^16)
//   idle                 no reads in flight and last issued slot was BUBBLE
// -----------------------------------------------------------------------------
module smem_bck_scheduler #(
   parameter int MAX_INFLIGHT = 8,
   parameter int CNT_W        = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             sched_en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [8:0]       in_read_num,
   input  logic [6:0]       in_forward_size,
   input  logic [5:0]       ret_status,
   input  logic             ret_finish,
   input  logic [8:0]       ret_read_num,
   output logic [5:0]       out_status,
   output logic [8:0]       out_read_num,
   output logic             out_inject,
   output logic [6:0]       out_forward_size_n,
   output logic [6:0]       out_backward_i,
   output logic [6:0]       out_backward_j,
   output logic             done_valid,
   output logic [8:0]       done_read_num,
   output logic [CNT_W-1:0] inflight,
   output logic [15:0]      retired_cnt,
   output logic             idle
);

   localparam logic [5:0]       BCK_INI = 6'h04;
   localparam logic [5:0]       BCK_RUN = 6'h05;
   localparam logic [5:0]       BUBBLE  = 6'h30;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Start position of the backward phase: last forward index, never below 0.
   function automatic logic [6:0] backward_start(input logic [6:0] fsize);
      if (fsize == 7'd0) begin
         return 7'd0;
      end else begin
         return fsize - 7'd1;
      end
   endfunction

   logic             ret_live_s;
   logic             ret_retire_s;
   logic             retire_ok_s;
   logic             cap_ok_s;
   logic             inject_s;

   logic [5:0]       out_status_q,         out_status_d;
   logic [8:0]       out_read_num_q,       out_read_num_d;
   logic             out_inject_q,         out_inject_d;
   logic [6:0]       out_forward_size_n_q, out_forward_size_n_d;
   logic [6:0]       out_backward_i_q,     out_backward_i_d;
   logic             done_valid_q,         done_valid_d;
   logic [8:0]       done_read_num_q,      done_read_num_d;
   logic [CNT_W-1:0] inflight_q,           inflight_d;
   logic [15:0]      retired_cnt_q,        retired_cnt_d;
   logic             idle_q,               idle_d;

   // Classify the returning token; finish_sign only matters on BCK_RUN.
   always_comb begin
      ret_live_s   = 1'b0;
      ret_retire_s = 1'b0;
      case (ret_status)
         BCK_INI: begin
            ret_live_s = 1'b1;
         end
         BCK_RUN: begin
            if (ret_finish) begin
               ret_retire_s = 1'b1;
            end else begin
               ret_live_s = 1'b1;
            end
         end
         default: begin
            ret_live_s   = 1'b0;
            ret_retire_s = 1'b0;
         end
      endcase
   end

   // A retire with nothing in flight is bogus and must not touch the counters.
   assign retire_ok_s = ret_retire_s & (inflight_q != {CNT_W{1'b0}});
   // A same-cycle retire hands its credit straight to the new read.
   assign cap_ok_s    = (inflight_q < MAX_CNT) | retire_ok_s;
   assign in_ready    = ~stall & sched_en & ~ret_live_s & cap_ok_s;
   assign inject_s    = in_valid & in_ready;

   // Next-state: slot selection, retire report and accounting.
   always_comb begin
      out_status_d         = out_status_q;
      out_read_num_d       = out_read_num_q;
      out_inject_d         = out_inject_q;
      out_forward_size_n_d = out_forward_size_n_q;
      out_backward_i_d     = out_backward_i_q;
      done_valid_d         = done_valid_q;
      done_read_num_d      = done_read_num_q;
      inflight_d           = inflight_q;
      retired_cnt_d        = retired_cnt_q;

      if (!stall) begin
         if (ret_live_s) begin
            out_status_d         = BCK_RUN;
            out_read_num_d       = ret_read_num;
            out_inject_d         = 1'b0;
            out_forward_size_n_d = 7'd0;
            out_backward_i_d     = 7'd0;
         end else if (inject_s) begin
            out_status_d         = BCK_INI;
            out_read_num_d       = in_read_num;
            out_inject_d         = 1'b1;
            out_forward_size_n_d = in_forward_size;
            out_backward_i_d     = backward_start(in_forward_size);
         end else begin
            out_status_d         = BUBBLE;
            out_read_num_d       = 9'd0;
            out_inject_d         = 1'b0;
            out_forward_size_n_d = 7'd0;
            out_backward_i_d     = 7'd0;
         end

         done_valid_d = retire_ok_s;
         if (retire_ok_s) begin
            done_read_num_d = ret_read_num;
            retired_cnt_d   = retired_cnt_q + 16'd1;
         end else begin
            done_read_num_d = 9'd0;
            retired_cnt_d   = retired_cnt_q;
         end

         case ({inject_s, retire_ok_s})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
         endcase
      end else begin
         done_valid_d = done_valid_q;
      end

      // Derived from the next values so it stays consistent across stalls.
      idle_d = (inflight_d == {CNT_W{1'b0}}) && (out_status_d == BUBBLE);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_status_q         <= BUBBLE;
         out_read_num_q       <= 9'd0;
         out_inject_q         <= 1'b0;
         out_forward_size_n_q <= 7'd0;
         out_backward_i_q     <= 7'd0;
         done_valid_q         <= 1'b0;
         done_read_num_q      <= 9'd0;
         inflight_q           <= {CNT_W{1'b0}};
         retired_cnt_q        <= 16'd0;
         idle_q               <= 1'b1;
      end else begin
         out_status_q         <= out_status_d;
         out_read_num_q       <= out_read_num_d;
         out_inject_q         <= out_inject_d;
         out_forward_size_n_q <= out_forward_size_n_d;
         out_backward_i_q     <= out_backward_i_d;
         done_valid_q         <= done_valid_d;
         done_read_num_q      <= done_read_num_d;
         inflight_q           <= inflight_d;
         retired_cnt_q        <= retired_cnt_d;
         idle_q               <= idle_d;
      end
   end

   assign out_status         = out_status_q;
   assign out_read_num       = out_read_num_q;
   assign out_inject         = out_inject_q;
   assign out_forward_size_n = out_forward_size_n_q;
   assign out_backward_i     = out_backward_i_q;
   assign out_backward_j     = 7'd0;
   assign done_valid         = done_valid_q;
   assign done_read_num      = done_read_num_q;
   assign inflight           = inflight_q;
   assign retired_cnt        = retired_cnt_q;
   assign idle               = idle_q;

endmodule

// File: tb/tb_smem_bck_scheduler.sv
// -----------------------------------------------------------------------------
// tb_smem_bck_scheduler
//
// Closes the pipeline loop with a behavioural ring of RING slots holding
// tokens (status, read index, remaining iterations). Each cycle the driver
// derives ret_* from the ring, predicts the scheduler response from the
// scheduling rules, checks in_ready and pushes the predicted registered
// outputs into a scoreboard. A monitor pops one entry after every clock edge
// and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_smem_bck_scheduler;

   localparam int MAX_INFLIGHT = 3;
   localparam int CNT_W        = 7;
   localparam int RING         = 5;

   localparam logic [5:0] BCK_INI = 6'h04;
   localparam logic [5:0] BCK_RUN = 6'h05;
   localparam logic [5:0] BUBBLE  = 6'h30;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             stall = 1'b0;
   logic             sched_en = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [8:0]       in_read_num = 9'd0;
   logic [6:0]       in_forward_size = 7'd0;
   logic [5:0]       ret_status = 6'h30;
   logic             ret_finish = 1'b0;
   logic [8:0]       ret_read_num = 9'd0;
   logic [5:0]       out_status;
   logic [8:0]       out_read_num;
   logic             out_inject;
   logic [6:0]       out_forward_size_n;
   logic [6:0]       out_backward_i;
   logic [6:0]       out_backward_j;
   logic             done_valid;
   logic [8:0]       done_read_num;
   logic [CNT_W-1:0] inflight;
   logic [15:0]      retired_cnt;
   logic             idle;

   always #5 clk = ~clk;

   smem_bck_scheduler #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .sched_en(sched_en),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_read_num(in_read_num), .in_forward_size(in_forward_size),
      .ret_status(ret_status), .ret_finish(ret_finish), .ret_read_num(ret_read_num),
      .out_status(out_status), .out_read_num(out_read_num), .out_inject(out_inject),
      .out_forward_size_n(out_forward_size_n), .out_backward_i(out_backward_i),
      .out_backward_j(out_backward_j), .done_valid(done_valid),
      .done_read_num(done_read_num), .inflight(inflight),
      .retired_cnt(retired_cnt), .idle(idle)
   );

   typedef struct {
      logic [5:0] st;
      logic [8:0] rn;
      logic       inj;
      logic [6:0] fs;
      logic [6:0] bi;
      logic       dv;
      logic [8:0] drn;
      int         infl;
      int         retired;
      logic       idle;
   } exp_t;

   typedef struct {
      logic [5:0] st;
      logic [8:0] rn;
      int         life;
   } tok_t;

   exp_t sb_q[$];
   exp_t last_exp;
   tok_t ring[RING];
   int   ptr = 0;
   int   m_count = 0;
   int   m_retired = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic clear_ring();
      for (int i = 0; i < RING; i++) begin
         ring[i].st   = BUBBLE;
         ring[i].rn   = 9'd0;
         ring[i].life = 0;
      end
      ptr = 0;
   endtask

   // One clock of stimulus plus the predicted response.
   task automatic do_cycle(input logic rst_v, input logic stall_v, input logic en_v,
                           input logic iv, input logic [8:0] rd, input logic [6:0] fs,
                           input logic stray);
      exp_t       e;
      tok_t       tok;
      tok_t       nt;
      logic [5:0] rs;
      logic       rf;
      logic [8:0] rrn;
      bit         live, retire, reff, rdy, inj;
      @(negedge clk);
      rst = rst_v; stall = stall_v; sched_en = en_v;
      in_valid = iv; in_read_num = rd; in_forward_size = fs;
      if (!rst_v) begin
         ret_status = 6'($urandom); ret_finish = 1'($urandom); ret_read_num = 9'($urandom);
         clear_ring();
         m_count = 0; m_retired = 0;
         e = '{st: BUBBLE, rn: 9'd0, inj: 1'b0, fs: 7'd0, bi: 7'd0, dv: 1'b0,
               drn: 9'd0, infl: 0, retired: 0, idle: 1'b1};
      end else if (stall_v) begin
         // The ring is frozen; whatever sits on ret_* must be ignored.
         ret_status = 6'($urandom); ret_finish = 1'($urandom); ret_read_num = 9'($urandom);
         #1 chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
         e = last_exp;
      end else begin
         tok = ring[ptr];
         if (tok.st == BUBBLE) begin
            rrn = 9'($urandom);
            if (stray && m_count == 0) begin
               rs = BCK_RUN; rf = 1'b1;
            end else begin
               case ($urandom_range(0, 5))
                  0: rs = 6'h3F;
                  1: rs = 6'h00;
                  2: rs = 6'h07;
                  default: rs = BUBBLE;
               endcase
               rf = 1'($urandom);
            end
         end else begin
            rs  = tok.st;
            rrn = tok.rn;
            rf  = (tok.st == BCK_INI) ? 1'($urandom) : (tok.life == 0);
         end
         ret_status = rs; ret_finish = rf; ret_read_num = rrn;

         live   = (rs == BCK_INI) || (rs == BCK_RUN && !rf);
         retire = (rs == BCK_RUN) && rf;
         reff   = retire && (m_count > 0);
         rdy    = en_v && !live && ((m_count < MAX_INFLIGHT) || reff);
         inj    = iv && rdy;
         #1 chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});

         if (live) begin
            e.st = BCK_RUN; e.rn = rrn; e.inj = 1'b0; e.fs = 7'd0; e.bi = 7'd0;
            nt.st = BCK_RUN; nt.rn = rrn;
            nt.life = (rs == BCK_INI) ? tok.life : tok.life - 1;
         end else if (inj) begin
            e.st = BCK_INI; e.rn = rd; e.inj = 1'b1; e.fs = fs;
            e.bi = (fs == 7'd0) ? 7'd0 : fs - 7'd1;
            nt.st = BCK_INI; nt.rn = rd; nt.life = $urandom_range(1, 3);
         end else begin
            e.st = BUBBLE; e.rn = 9'd0; e.inj = 1'b0; e.fs = 7'd0; e.bi = 7'd0;
            nt.st = BUBBLE; nt.rn = 9'd0; nt.life = 0;
         end
         ring[ptr] = nt;
         ptr = (ptr + 1) % RING;
         m_count   = m_count + (inj ? 1 : 0) - (reff ? 1 : 0);
         m_retired = (m_retired + (reff ? 1 : 0)) % 65536;
         e.dv = reff; e.drn = rrn; e.infl = m_count; e.retired = m_retired;
         e.idle = (m_count == 0) && (e.st == BUBBLE);
      end
      last_exp = e;
      sb_q.push_back(e);
   endtask

   task automatic rand_cycle(input logic en_v, input int stall_pct);
      logic [6:0] fs;
      fs = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom);
      do_cycle(1'b1, ($urandom_range(0, 99) < stall_pct), en_v,
               ($urandom_range(0, 3) != 0), 9'($urandom), fs, 1'b0);
   endtask

   // Monitor: every edge produces exactly one predicted response.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("out_status",   {26'd0, out_status},         {26'd0, e.st});
            chk("out_read_num", {23'd0, out_read_num},       {23'd0, e.rn});
            chk("out_inject",   {31'd0, out_inject},         {31'd0, e.inj});
            chk("out_fwd_size", {25'd0, out_forward_size_n}, {25'd0, e.fs});
            chk("out_bwd_i",    {25'd0, out_backward_i},     {25'd0, e.bi});
            chk("out_bwd_j",    {25'd0, out_backward_j},     32'd0);
            chk("done_valid",   {31'd0, done_valid},         {31'd0, e.dv});
            if (e.dv) chk("done_read_num", {23'd0, done_read_num}, {23'd0, e.drn});
            chk("inflight",     {25'd0, inflight},           e.infl);
            chk("retired_cnt",  {16'd0, retired_cnt},        e.retired);
            chk("idle",         {31'd0, idle},               {31'd0, e.idle});
         end
      end
   end

   initial begin
      clear_ring();
      // Reset and its observable state.
      do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 9'd0, 7'd0, 1'b0);
      do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 9'd0, 7'd0, 1'b0);
      // First read: 5, forward size 20.
      do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 9'd5, 7'd20, 1'b0);
      // Keep offering so the credit limit and live-return priority bite.
      for (int i = 0; i < 12; i++) do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 9'(100 + i), 7'(i), 1'b0);
      for (int i = 0; i < 150; i++) rand_cycle(1'b1, 10);
      // Three-cycle stall in the middle of traffic.
      for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 1'b1, 1'b1, 9'd7, 7'd9, 1'b0);
      for (int i = 0; i < 40; i++) rand_cycle(1'b1, 0);
      // Explicit zero-size injection attempts.
      for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 9'(300 + i), 7'd0, 1'b0);
      // Drain: only recirculation and retirement.
      for (int i = 0; i < 45; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 9'd77, 7'd3, 1'b0);
      // Bogus retire with nothing in flight.
      do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 9'd0, 7'd0, 1'b1);
      do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 9'd0, 7'd0, 1'b1);
      for (int i = 0; i < 100; i++) rand_cycle(1'b1, 15);
      // Reset in the middle of traffic, then carry on and drain again.
      do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 9'd1, 7'd1, 1'b0);
      for (int i = 0; i < 60; i++) rand_cycle(1'b1, 10);
      for (int i = 0; i < 45; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 7'd0, 1'b0);

      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
